imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter IMEM_WORDS, default 396, SHALL give the instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 32, SHALL give the byte-address width.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Req0/Req1  input  1 each  SHALL be the read requests from fetch (0) and loader/debug (1).
REQ-006 Addr0/Addr1  input  ADDR_W each  SHALL be the byte addresses for each requester.
REQ-007 Gnt0/Gnt1  output  1 each  SHALL be single-cycle request-accept pulses.
REQ-008 RespValid0/RespValid1  output  1 each  SHALL flag a response held for that port.
REQ-009 RespReady0/RespReady1  input  1 each  SHALL be the response acceptance from each port.
REQ-010 RespData  output  32  SHALL be the shared registered instruction word.
REQ-011 RespErr  output  1  SHALL flag a misaligned or out-of-range request.
REQ-012 MemAddress  output  ADDR_W  SHALL drive the combinational instruction memory address.
REQ-013 MemInstruction  input  32  SHALL be the combinational memory read data.

Function
REQ-014 The FSM SHALL have states IDLE, READ and RESP.
REQ-015 In IDLE with any Req, the FSM SHALL pulse the winner's Gnt, register its address into MemAddress and go to READ.
REQ-016 Arbitration SHALL be round-robin: on simultaneous Req0/Req1, the port not granted last wins; a lone request always wins.
REQ-017 In READ, the FSM SHALL capture MemInstruction into RespData and go to RESP.
REQ-018 In RESP, only the granted port's RespValid SHALL be 1; RespData/RespErr SHALL stay stable until RespReady of that port is sampled 1.
REQ-019 On RESP with Ready, if any Req is high the FSM SHALL grant per REQ-016 in that same cycle and go to READ; otherwise it SHALL go to IDLE.
REQ-020 Latency SHALL be Gnt in cycle N, RespValid in cycle N+2; peak throughput one read per 2 cycles.
REQ-021 RespErr SHALL be 1 when Addr[1:0]!=0 or Addr[ADDR_W-1:2] >= IMEM_WORDS; RespData SHALL then be 0 and the handshake completes normally.
REQ-022 In-range word index SHALL be Addr[ADDR_W-1:2]; no wrap-around is permitted.
REQ-023 Req SHALL be ignored while in READ or RESP (no Gnt), except at the REQ-019 handover.
REQ-024 A Req deasserted before its Gnt SHALL be dropped with no side effect.

Reset
REQ-025 While Reset_n=0: state IDLE, Gnt*=0, RespValid*=0, RespData=0, RespErr=0, MemAddress=0, last-grant pointer=port 1 (port 0 first).
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; no response SHALL be issued after release.

Structure
REQ-027 IMEM_WORDS, state encoding and port-index constants SHALL live in the shared package mips_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_arb2 (2 requests, last-grant pointer, grant vector).
REQ-029 The memory SHALL remain external; this block SHALL hold no memory array.

Verification
REQ-030 Req0=1, Addr0=0x8, mem[2]=0x2002000A, RespReady0=1 -> Gnt0 cycle N, RespValid0 N+2, RespData=0x2002000A, RespErr=0.
REQ-031 Req0=Req1=1 held continuously, Ready=1 -> grants alternate 0,1,0,1 each 2 cycles, starting with port 0.
REQ-032 Req1, Addr1=0x6 -> RespValid1 with RespErr=1, RespData=0; Addr1=0x630 (word 396) -> RespErr=1.
REQ-033 RespReady0=0 for 5 cycles in RESP with Req1 high -> RespData stable, no Gnt1 until Ready0 sampled 1, then Gnt1 that cycle.
REQ-034 Reset_n low during READ -> all outputs 0 asynchronously; after release no RespValid until a new Gnt.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
//   IMEM_WORDS  : default instruction-memory depth in 32-bit words
//   arb_state_e : arbiter FSM state encoding
//   PORT_FETCH / PORT_LOADER : requester indices (fetch = 0, loader/debug = 1)
package mips_pkg;

  localparam int unsigned IMEM_WORDS = 32'd396;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic PORT_FETCH  = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/imem_arbiter_if.sv
// Request/response and memory-side bundle of the instruction-memory arbiter.
//   Req0/Req1, Addr0/Addr1       : read requests and byte addresses per port
//   Gnt0/Gnt1                    : single-cycle accept pulses
//   RespValid*/RespReady*        : per-port response handshake
//   RespData/RespErr             : shared response word and error flag
//   MemAddress/MemInstruction    : combinational external memory port
// slave  = arbiter side, master = requesters plus memory side.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 32'd32
);
  logic              Req0;
  logic              Req1;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic              Gnt0;
  logic              Gnt1;
  logic              RespValid0;
  logic              RespValid1;
  logic              RespReady0;
  logic              RespReady1;
  logic [31:0]       RespData;
  logic              RespErr;
  logic [ADDR_W-1:0] MemAddress;
  logic [31:0]       MemInstruction;

  modport slave (
    input  Req0, Req1, Addr0, Addr1, RespReady0, RespReady1, MemInstruction,
    output Gnt0, Gnt1, RespValid0, RespValid1, RespData, RespErr, MemAddress
  );

  modport master (
    output Req0, Req1, Addr0, Addr1, RespReady0, RespReady1, MemInstruction,
    input  Gnt0, Gnt1, RespValid0, RespValid1, RespData, RespErr, MemAddress
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector with a last-grant pointer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req[1:0]     : request vector (bit 0 = fetch, bit 1 = loader)
//   i_en           : grant permitted this cycle
//   o_gnt[1:0]     : one-hot grant vector (combinational)
//   o_gnt_idx      : index of the granted port
module rr_arb2
  import mips_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx
);

  logic       r_last;
  logic [1:0] w_gnt;
  logic       w_idx;

  // Pick the winner: on a tie the port not granted last wins.
  always_comb begin
    w_gnt = 2'b00;
    w_idx = PORT_FETCH;
    if (!i_en) begin
      w_gnt = 2'b00;
    end else if (i_req == 2'b11) begin
      if (r_last == PORT_LOADER) begin
        w_gnt = 2'b01;
        w_idx = PORT_FETCH;
      end else begin
        w_gnt = 2'b10;
        w_idx = PORT_LOADER;
      end
    end else if (i_req[0]) begin
      w_gnt = 2'b01;
      w_idx = PORT_FETCH;
    end else if (i_req[1]) begin
      w_gnt = 2'b10;
      w_idx = PORT_LOADER;
    end else begin
      w_gnt = 2'b00;
    end
  end

  // Last-grant pointer; reset points at the loader so fetch goes first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PORT_LOADER;
    end else if (w_gnt != 2'b00) begin
      r_last <= w_idx;
    end else begin
      r_last <= r_last;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates two read requesters onto one external combinational
// instruction memory. Grant in cycle N, response valid in cycle N+2;
// a handshake in RESP can hand over directly to the next grant.
//   Clk     : clock (rising edge)
//   Reset_n : asynchronous active-low reset
//   bus     : imem_arbiter_if.slave (requests, grants, responses, memory port)
module imem_arbiter #(
  parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS,
  parameter int unsigned ADDR_W     = 32'd32
) (
  input logic           Clk,
  input logic           Reset_n,
  imem_arbiter_if.slave bus
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] LP_WORDS = ADDR_W'(IMEM_WORDS);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_pend;
  logic [31:0]       r_data;
  logic              r_err;
  logic [1:0]        r_valid;

  logic              w_ready;
  logic              w_grant_ok;
  logic [1:0]        w_gnt;
  logic              w_gnt_idx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_err;

  rr_arb2 u_rr (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_req     ({bus.Req1, bus.Req0}),
    .i_en      (w_grant_ok),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Grant window: IDLE, or RESP when the holder accepts. Reset_n gates the
  // grant so no pulse escapes while reset is held.
  always_comb begin
    w_ready    = (r_port == PORT_FETCH) ? bus.RespReady0 : bus.RespReady1;
    w_grant_ok = 1'b0;
    case (r_state)
      ST_IDLE: w_grant_ok = Reset_n;
      ST_RESP: w_grant_ok = Reset_n & w_ready;
      ST_READ: w_grant_ok = 1'b0;
      default: w_grant_ok = 1'b0;
    endcase
  end

  // Address of the winner and its error classification.
  always_comb begin
    w_sel_addr = (w_gnt_idx == PORT_FETCH) ? bus.Addr0 : bus.Addr1;
    w_sel_err  = 1'b0;
    if (w_sel_addr[1:0] != 2'b00) begin
      w_sel_err = 1'b1;
    end else if ({2'b00, w_sel_addr[ADDR_W-1:2]} >= LP_WORDS) begin
      w_sel_err = 1'b1;
    end else begin
      w_sel_err = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt != 2'b00) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: w_next_state = ST_RESP;
      ST_RESP: begin
        if (!w_ready) begin
          w_next_state = ST_RESP;
        end else if (w_gnt != 2'b00) begin
          w_next_state = ST_READ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request capture on grant, response capture in READ, release on handshake.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_port     <= PORT_FETCH;
      r_addr     <= '0;
      r_err_pend <= 1'b0;
      r_data     <= 32'h0000_0000;
      r_err      <= 1'b0;
      r_valid    <= 2'b00;
    end else begin
      if (w_gnt != 2'b00) begin
        r_port     <= w_gnt_idx;
        r_addr     <= w_sel_addr;
        r_err_pend <= w_sel_err;
      end
      if (r_state == ST_READ) begin
        // Erroneous requests never expose memory contents.
        r_data  <= r_err_pend ? 32'h0000_0000 : bus.MemInstruction;
        r_err   <= r_err_pend;
        r_valid <= (r_port == PORT_LOADER) ? 2'b10 : 2'b01;
      end else if ((r_state == ST_RESP) && w_ready) begin
        r_valid <= 2'b00;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign bus.Gnt0       = w_gnt[0];
  assign bus.Gnt1       = w_gnt[1];
  assign bus.RespValid0 = r_valid[0];
  assign bus.RespValid1 = r_valid[1];
  assign bus.RespData   = r_data;
  assign bus.RespErr    = r_err;
  assign bus.MemAddress = r_addr;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus pushes expected grants and
// responses; a negedge monitor pops and compares them.
module tb_imem_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic Clk;
  logic Reset_n;
  int   n_tests;
  int   n_fail;
  int   cyc;
  int   last_gnt_cyc;
  logic [1:0] prev_rv;

  exp_t sb[$];
  logic gq[$];
  logic [31:0] mem [0:395];

  imem_arbiter_if #(.ADDR_W(32)) bus ();

  imem_arbiter #(.IMEM_WORDS(396), .ADDR_W(32)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // External memory model; out-of-range reads return all ones.
  assign bus.MemInstruction = ((bus.MemAddress >> 2) < 32'd396) ?
                              mem[bus.MemAddress[10:2]] : 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency, grant order and response contents.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if ({bus.RespValid1, bus.RespValid0} != 2'b00 && prev_rv == 2'b00)
        check("latency", 64'(cyc - last_gnt_cyc), 64'd2);
      if (bus.RespValid0 && bus.RespValid1)
        check("valid_onehot", 64'd1, 64'd0);
      if ((bus.RespValid0 && bus.RespReady0) || (bus.RespValid1 && bus.RespReady1)) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_port", 64'(bus.RespValid1), 64'(e.port));
          check("resp_data", 64'(bus.RespData), 64'(e.data));
          check("resp_err", 64'(bus.RespErr), 64'(e.err));
        end
      end
      if (bus.Gnt0 || bus.Gnt1) begin
        last_gnt_cyc = cyc;
        if (bus.Gnt0 && bus.Gnt1) check("gnt_onehot", 64'd1, 64'd0);
        if (gq.size() == 0) begin
          check("unexpected_gnt", 64'd1, 64'd0);
        end else begin
          logic ep;
          ep = gq.pop_front();
          check("gnt_port", 64'(bus.Gnt1), 64'(ep));
        end
      end
      prev_rv = {bus.RespValid1, bus.RespValid0};
    end else begin
      prev_rv = 2'b00;
    end
  end

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  // Raise one request, wait for its grant, then drop it.
  task automatic issue(input logic port, input logic [31:0] addr,
                       input logic [31:0] d, input logic e, input bit track);
    logic got;
    @(posedge Clk);
    #1;
    if (port) begin bus.Req1 = 1'b1; bus.Addr1 = addr; end
    else      begin bus.Req0 = 1'b1; bus.Addr0 = addr; end
    gq.push_back(port);
    if (track) sb.push_back('{port: port, data: d, err: e});
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge Clk);
      got = port ? bus.Gnt1 : bus.Gnt0;
    end
    if (!got) check("gnt_timeout", 64'd0, 64'd1);
    @(posedge Clk);
    #1;
    if (port) bus.Req1 = 1'b0;
    else      bus.Req0 = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(negedge Clk);
      i++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; last_gnt_cyc = 0; prev_rv = 2'b00;
    for (int i = 0; i < 396; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[2] = 32'h2002_000A;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.Addr0 = 32'h0; bus.Addr1 = 32'h0;
    bus.RespReady0 = 1'b1; bus.RespReady1 = 1'b1;
    Reset_n = 1'b0;

    // Reset state, with a request pending that must not be granted.
    bus.Req0 = 1'b1; bus.Addr0 = 32'h8;
    repeat (2) @(negedge Clk);
    check("rst_gnt0", 64'(bus.Gnt0), 64'd0);
    check("rst_gnt1", 64'(bus.Gnt1), 64'd0);
    check("rst_valid0", 64'(bus.RespValid0), 64'd0);
    check("rst_valid1", 64'(bus.RespValid1), 64'd0);
    check("rst_data", 64'(bus.RespData), 64'd0);
    check("rst_err", 64'(bus.RespErr), 64'd0);
    check("rst_maddr", 64'(bus.MemAddress), 64'd0);
    bus.Req0 = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Single reads: normal, misaligned, out of range, last word.
    issue(1'b0, 32'h0000_0008, 32'h2002_000A, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b1);
    issue(1'b1, 32'h0000_0630, 32'h0000_0000, 1'b1, 1'b1);
    issue(1'b0, 32'h0000_062C, 32'hC0DE_018B, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_0004, 32'hC0DE_0001, 1'b0, 1'b1);
    wait_idle();

    // Back-pressure on port 0 with port 1 waiting.
    bus.RespReady0 = 1'b0;
    issue(1'b0, 32'h0000_0008, 32'h2002_000A, 1'b0, 1'b1);
    bus.Req1 = 1'b1; bus.Addr1 = 32'h14;
    gq.push_back(1'b1);
    sb.push_back('{port: 1'b1, data: 32'hC0DE_0005, err: 1'b0});
    for (int i = 0; i < 10 && !bus.RespValid0; i++) @(negedge Clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid0", 64'(bus.RespValid0), 64'd1);
      check("bp_data", 64'(bus.RespData), 64'h2002_000A);
      check("bp_no_gnt1", 64'(bus.Gnt1), 64'd0);
      @(negedge Clk);
    end
    @(posedge Clk);
    #1 bus.RespReady0 = 1'b1;
    @(negedge Clk);
    check("bp_handover_gnt1", 64'(bus.Gnt1), 64'd1);
    @(posedge Clk);
    #1 bus.Req1 = 1'b0;
    wait_idle();

    // Reset during READ aborts the transaction.
    issue(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_valid0", 64'(bus.RespValid0), 64'd0);
    check("abort_data", 64'(bus.RespData), 64'd0);
    check("abort_maddr", 64'(bus.MemAddress), 64'd0);
    check("abort_gnt0", 64'(bus.Gnt0), 64'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check("abort_no_resp", 64'({bus.RespValid1, bus.RespValid0}), 64'd0);
    end

    // Round-robin with both requests held, starting from reset.
    do_reset();
    @(posedge Clk);
    #1;
    bus.Req0 = 1'b1; bus.Addr0 = 32'h10;
    bus.Req1 = 1'b1; bus.Addr1 = 32'h14;
    for (int k = 0; k < 6; k++) begin
      logic p;
      p = k[0];
      gq.push_back(p);
      sb.push_back('{port: p, data: (p ? 32'hC0DE_0005 : 32'hC0DE_0004), err: 1'b0});
    end
    begin
      int prev_c;
      prev_c = 0;
      for (int k = 0; k < 6; k++) begin
        int i;
        i = 0;
        do begin
          @(negedge Clk);
          i++;
        end while (!(bus.Gnt0 || bus.Gnt1) && i < 20);
        if (k > 0) check("rr_spacing", 64'(cyc - prev_c), 64'd2);
        prev_c = cyc;
      end
    end
    @(posedge Clk);
    #1;
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    wait_idle();

    check("sb_empty", 64'(sb.size()), 64'd0);
    check("gq_empty", 64'(gq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
